picosoc_bus_arbiter: RTL and testbench
======================================

Name: picosoc_bus_arbiter

Overview:
Two-master arbiter sharing the PicoSoC native memory bus (valid/ready/addr/wdata/wstrb/rdata) between the CPU (master 0) and a secondary master such as a loader/DMA (master 1).
Sits between the masters and the SoC address decoder, which sees a single master.
Round-robin grant, held for a whole transaction, plus a bus watchdog that terminates transactions to unresponsive slaves.

Parameters:
TIMEOUT_CYCLES, 255, cycles in BUSY without s_ready before forced termination; 0 disables the watchdog
TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on a timed-out transaction
FIXED_PRIO, 0, 1 = master 0 always wins simultaneous requests; 0 = round-robin

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_valid  in  1  master 0 request
m0_ready  out  1  master 0 completion strobe
m0_addr  in  32  master 0 address
m0_wdata  in  32  master 0 write data
m0_wstrb  in  4  master 0 byte strobes (0 = read)
m0_rdata  out  32  master 0 read data
m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata  same as m0_*, for master 1
s_valid  out  1  request to the decoder/slaves
s_ready  in  1  slave completion
s_addr  out  32  muxed address
s_wdata  out  32  muxed write data
s_wstrb  out  4  muxed strobes
s_rdata  in  32  slave read data
grant_id  out  1  master currently owning the bus (valid while busy)
busy  out  1  transaction in progress
timeout_pulse  out  1  one-cycle pulse on watchdog termination (IRQ source)

Behaviour:
- Reset (sync, high): state=IDLE, last_grant=1 (master 0 wins first), wd_cnt=0. All outputs 0: s_valid, m*_ready, busy, grant_id, timeout_pulse.
- States: IDLE, BUSY.
- IDLE:
  - No valid: stay.
  - Exactly one valid: grant that master.
  - Both valid: grant !last_grant, or 0 if FIXED_PRIO.
  - On grant, register grant_id and go to BUSY. Arbitration latency is 1 cycle.
  - s_valid=0 in IDLE.
- BUSY:
  - s_valid = valid of the granted master.
  - s_addr/s_wdata/s_wstrb are combinationally muxed from the granted master.
  - Non-granted master: ready=0; its request is held pending.
- Completion (BUSY and s_ready and s_valid):
  - Granted m*_ready=1 for exactly that cycle; m*_rdata=s_rdata, combinational.
  - last_grant<=grant_id; next state IDLE.
  - Minimum transaction time is slave latency + 1 cycle. No back-to-back grants without an IDLE cycle.
- rdata of the non-granted master is 0. rdata of the granted master outside its ready cycle is 0.
- Watchdog:
  - wd_cnt increments each BUSY cycle without s_ready.
  - When wd_cnt==TIMEOUT_CYCLES-1 and s_ready==0:
    - Granted ready=1 and rdata=TIMEOUT_RDATA for that cycle.
    - s_valid forced 0 that cycle.
    - timeout_pulse=1; go to IDLE; last_grant updated.
  - wd_cnt clears on leaving BUSY. Counter width is $clog2(TIMEOUT_CYCLES+1).
  - s_ready in the same cycle as expiry: normal completion wins, no pulse.
- Granted master drops valid in BUSY (abort): return to IDLE with no ready and no pulse; last_grant unchanged.
- Addresses, data and strobes pass through unmodified; the arbiter never decodes addresses.
- Reset mid-transaction: immediate return to reset state. Outputs are 0 in the cycle after the reset edge. No ready is issued for the aborted transaction.

Decomposition:
- Package picosoc_bus_pkg: state enum (IDLE, BUSY), master index type, TIMEOUT_RDATA default, bus width constants (ADDR_W=32, DATA_W=32, STRB_W=4).
- One sub-module: picosoc_rr_arb2. Combinational 2-way round-robin pick from req[1:0], last_grant and fixed_prio. Outputs gnt_id and gnt_vld.
- FSM, watchdog and muxes live in the top module.

Test Plan:
1. Single master read: m0_valid, addr 0x0000_0100; slave returns ready 2 cycles after s_valid with 0x1234_5678 -> m0_ready one cycle, m0_rdata=0x1234_5678, grant_id=0, m1_ready never high.
2. Simultaneous requests, 4 rounds, both held valid, slave 1-cycle latency -> grant order 0,1,0,1. With FIXED_PRIO=1 -> 0,0,0,0 while m0 stays valid.
3. Write with wstrb=4'b0011, data 0xAABB_CCDD from m1 while m0 idle -> s_wstrb=0011, s_wdata=0xAABB_CCDD, s_addr=m1_addr during BUSY; m1_ready on the s_ready cycle.
4. Watchdog, TIMEOUT_CYCLES=8, slave never ready -> m0_ready and timeout_pulse on the 8th BUSY cycle, m0_rdata=0xDEAD_BEEF, s_valid=0 that cycle, next request granted to m1 if pending.
5. Expiry coincidence: s_ready on exactly cycle 8 -> normal completion with slave data, timeout_pulse=0.
6. reset asserted in BUSY with m1 granted -> next cycle all outputs 0, state IDLE; the first post-reset simultaneous request is granted to m0.

Source files
------------

// File: rtl/picosoc_bus_pkg.sv
// Shared types and constants for the PicoSoC two-master bus arbiter.
// Contents: bus widths, arbiter FSM state enum, master index type and
// the default read data returned on a watchdog-terminated transaction.
package picosoc_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [DATA_W-1:0] TIMEOUT_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  // Master 0 = CPU, master 1 = secondary master (loader/DMA).
  typedef logic mst_idx_t;

endpackage

// File: rtl/picosoc_rr_arb2.sv
// Combinational two-way arbiter pick.
// Ports:
//   req        - request vector, bit i = master i
//   last_grant - master that completed the most recent transaction
//   fixed_prio - 1: master 0 wins ties; 0: ties go to the master not in last_grant
//   gnt_id     - chosen master (only meaningful when gnt_vld)
//   gnt_vld    - at least one request present
module picosoc_rr_arb2
  import picosoc_bus_pkg::*;
(
  input  logic [1:0] req,
  input  mst_idx_t   last_grant,
  input  logic       fixed_prio,
  output mst_idx_t   gnt_id,
  output logic       gnt_vld
);

  always_comb begin
    gnt_vld = |req;
    gnt_id  = 1'b0;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = fixed_prio ? 1'b0 : ~last_grant;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/picosoc_bus_arbiter.sv
// Two-master arbiter for the PicoSoC native memory bus.
// Shares one slave-side bus between master 0 (CPU) and master 1 (loader/DMA).
// A grant is held for a whole transaction; an IDLE cycle separates grants.
// A watchdog terminates transactions whose slave never raises s_ready.
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   m{0,1}_valid/addr/wdata/wstrb  - master requests
//   m{0,1}_ready/rdata     - master completion strobe and read data
//   s_valid/addr/wdata/wstrb       - request towards the address decoder
//   s_ready/rdata          - slave completion and read data
//   grant_id               - owning master (0 when not busy)
//   busy                   - transaction in progress
//   timeout_pulse          - one-cycle pulse when the watchdog terminates a transaction
module picosoc_bus_arbiter
  import picosoc_bus_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = TIMEOUT_RDATA_DEFAULT,
  parameter bit                FIXED_PRIO     = 1'b0
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              s_valid,
  input  logic              s_ready,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic [DATA_W-1:0] s_rdata,

  output logic              grant_id,
  output logic              busy,
  output logic              timeout_pulse
);

  // Watchdog counter keeps a 1-bit floor so a disabled watchdog still elaborates.
  localparam int unsigned WdW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  arb_state_e     state_q, state_d;
  mst_idx_t       grant_q, grant_d;
  mst_idx_t       last_q, last_d;
  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;

  mst_idx_t    arb_id;
  logic        arb_vld;
  logic        gnt_valid;
  logic        wd_expire;
  logic        done;
  logic        tmo;
  logic [DATA_W-1:0] resp_data;

  picosoc_rr_arb2 u_rr_arb2 (
    .req        ({m1_valid, m0_valid}),
    .last_grant (last_q),
    .fixed_prio (FIXED_PRIO),
    .gnt_id     (arb_id),
    .gnt_vld    (arb_vld)
  );

  assign gnt_valid = grant_q ? m1_valid : m0_valid;
  assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WdLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    wd_cnt_d = wd_cnt_q;
    s_valid  = 1'b0;
    done     = 1'b0;
    tmo      = 1'b0;

    unique case (state_q)
      StIdle: begin
        wd_cnt_d = '0;
        if (arb_vld) begin
          grant_d = arb_id;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!gnt_valid) begin
          // Master withdrew its request: drop it silently, keep round-robin history.
          state_d  = StIdle;
          wd_cnt_d = '0;
        end else if (s_ready) begin
          // Slave response beats a coincident watchdog expiry.
          s_valid  = 1'b1;
          done     = 1'b1;
          last_d   = grant_q;
          state_d  = StIdle;
          wd_cnt_d = '0;
        end else if (wd_expire) begin
          done     = 1'b1;
          tmo      = 1'b1;
          last_d   = grant_q;
          state_d  = StIdle;
          wd_cnt_d = '0;
        end else begin
          s_valid  = 1'b1;
          wd_cnt_d = wd_cnt_q + WdW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy          = (state_q == StBusy);
  assign grant_id      = busy & grant_q;
  assign timeout_pulse = tmo;

  assign resp_data = tmo ? TIMEOUT_RDATA : s_rdata;
  assign m0_ready  = done & ~grant_q;
  assign m1_ready  = done & grant_q;
  assign m0_rdata  = m0_ready ? resp_data : '0;
  assign m1_rdata  = m1_ready ? resp_data : '0;

  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    if (busy) begin
      s_addr  = grant_q ? m1_addr  : m0_addr;
      s_wdata = grant_q ? m1_wdata : m0_wdata;
      s_wstrb = grant_q ? m1_wstrb : m0_wstrb;
    end
  end

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// Bench for picosoc_bus_arbiter: two instances (round-robin and fixed-priority,
// both with an 8-cycle watchdog) share one stimulus. A transaction-level model
// predicts every output each cycle; directed steps add explicit checks.
`timescale 1ns/1ps
module tb_picosoc_bus_arbiter;

  localparam int unsigned TMO = 8;
  localparam logic [31:0] TRD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;

  logic        o_m0_ready [2];
  logic [31:0] o_m0_rdata [2];
  logic        o_m1_ready [2];
  logic [31:0] o_m1_rdata [2];
  logic        o_s_valid  [2];
  logic [31:0] o_s_addr   [2];
  logic [31:0] o_s_wdata  [2];
  logic [3:0]  o_s_wstrb  [2];
  logic        o_grant_id [2];
  logic        o_busy     [2];
  logic        o_tmo      [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    picosoc_bus_arbiter #(
      .TIMEOUT_CYCLES (TMO),
      .TIMEOUT_RDATA  (TRD),
      .FIXED_PRIO     (g == 1)
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .m0_valid      (m0_valid),
      .m0_ready      (o_m0_ready[g]),
      .m0_addr       (m0_addr),
      .m0_wdata      (m0_wdata),
      .m0_wstrb      (m0_wstrb),
      .m0_rdata      (o_m0_rdata[g]),
      .m1_valid      (m1_valid),
      .m1_ready      (o_m1_ready[g]),
      .m1_addr       (m1_addr),
      .m1_wdata      (m1_wdata),
      .m1_wstrb      (m1_wstrb),
      .m1_rdata      (o_m1_rdata[g]),
      .s_valid       (o_s_valid[g]),
      .s_ready       (s_ready),
      .s_addr        (o_s_addr[g]),
      .s_wdata       (o_s_wdata[g]),
      .s_wstrb       (o_s_wstrb[g]),
      .s_rdata       (s_rdata),
      .grant_id      (o_grant_id[g]),
      .busy          (o_busy[g]),
      .timeout_pulse (o_tmo[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Model: owner = -1 when nobody holds the bus, else the owning master.
  // age = busy cycles already spent by the owner without a slave response.
  int owner [2];
  int age   [2];
  int last  [2];
  int fixed [2] = '{0, 1};

  function automatic logic [137:0] observed(input int k);
    return {o_s_valid[k], o_s_addr[k], o_s_wdata[k], o_s_wstrb[k], o_m0_ready[k],
            o_m0_rdata[k], o_m1_ready[k], o_m1_rdata[k], o_grant_id[k], o_busy[k], o_tmo[k]};
  endfunction

  function automatic logic [137:0] expected(input int k);
    logic        sv, r0, r1, gid, bz, tp, v, fin;
    logic [31:0] sa, sw, d0, d1, resp;
    logic [3:0]  ss;
    sv = 0; r0 = 0; r1 = 0; gid = 0; bz = 0; tp = 0; fin = 0;
    sa = 0; sw = 0; d0 = 0; d1 = 0; ss = 0; resp = 0;
    if (owner[k] >= 0) begin
      bz  = 1;
      gid = (owner[k] == 1);
      v   = (owner[k] == 1) ? m1_valid : m0_valid;
      sa  = (owner[k] == 1) ? m1_addr  : m0_addr;
      sw  = (owner[k] == 1) ? m1_wdata : m0_wdata;
      ss  = (owner[k] == 1) ? m1_wstrb : m0_wstrb;
      if (v) begin
        if (s_ready) begin
          sv = 1; fin = 1; resp = s_rdata;
        end else if (age[k] + 1 == TMO) begin
          fin = 1; tp = 1; resp = TRD;
        end else begin
          sv = 1;
        end
      end
      if (fin && owner[k] == 0) begin r0 = 1; d0 = resp; end
      if (fin && owner[k] == 1) begin r1 = 1; d1 = resp; end
    end
    return {sv, sa, sw, ss, r0, d0, r1, d1, gid, bz, tp};
  endfunction

  function automatic void advance(input int k);
    logic v;
    if (reset) begin
      owner[k] = -1; age[k] = 0; last[k] = 1;
      return;
    end
    if (owner[k] < 0) begin
      age[k] = 0;
      if (m0_valid && m1_valid) owner[k] = (fixed[k] != 0) ? 0 : 1 - last[k];
      else if (m0_valid)        owner[k] = 0;
      else if (m1_valid)        owner[k] = 1;
    end else begin
      v = (owner[k] == 1) ? m1_valid : m0_valid;
      if (!v) begin
        owner[k] = -1;
      end else if (s_ready || (age[k] + 1 == TMO)) begin
        last[k]  = owner[k];
        owner[k] = -1;
      end else begin
        age[k]++;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare both instances against the model mid-cycle.
  task automatic settle();
    logic [137:0] obs, exp;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      obs = observed(k);
      exp = expected(k);
      n_cmp++;
      assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL model_u%0d @%0t: observed %h expected %h", k, $time, obs, exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    advance(0);
    advance(1);
    #1;
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      settle();
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    m0_valid = 0; m1_valid = 0;
    m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    s_ready = 0; s_rdata = 0;
    for (int k = 0; k < 2; k++) begin owner[k] = -1; age[k] = 0; last[k] = 1; end
    @(posedge clk);
    advance(0);
    advance(1);
    #1;

    // Reset state: model compare covers every output.
    settle();
    chk("reset_busy", o_busy[0], 0);
    chk("reset_s_valid", o_s_valid[0], 0);
    tick();
    reset = 1'b0;

    // Single master read, slave answers on the third busy cycle.
    m0_valid = 1; m0_addr = 32'h0000_0100; m0_wstrb = 4'b0000; s_rdata = 32'h1111_0000;
    cycle(3);
    s_ready = 1; s_rdata = 32'h1234_5678;
    settle();
    chk("t1_m0_ready", o_m0_ready[0], 1);
    chk("t1_m0_rdata", o_m0_rdata[0], 32'h1234_5678);
    chk("t1_grant", o_grant_id[0], 0);
    chk("t1_m1_ready", o_m1_ready[0], 0);
    tick();
    m0_valid = 0; s_ready = 0;
    cycle(1);

    // Simultaneous requests, slave always ready.
    do_reset();
    m0_valid = 1; m1_valid = 1; s_ready = 1; s_rdata = 32'h5555_AAAA;
    m1_addr = 32'h2000_0000;
    for (int r = 0; r < 4; r++) begin
      cycle(1);
      settle();
      chk($sformatf("t2_rr_grant%0d", r), o_grant_id[0], r % 2);
      chk($sformatf("t2_fp_grant%0d", r), o_grant_id[1], 0);
      tick();
    end
    m0_valid = 0; m1_valid = 0; s_ready = 0;
    cycle(1);

    // Write from master 1 while master 0 idles.
    m1_valid = 1; m1_addr = 32'h2000_0040; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0011;
    cycle(1);
    settle();
    chk("t3_s_wstrb", o_s_wstrb[0], 4'b0011);
    chk("t3_s_wdata", o_s_wdata[0], 32'hAABB_CCDD);
    chk("t3_s_addr", o_s_addr[0], 32'h2000_0040);
    chk("t3_m1_ready_early", o_m1_ready[0], 0);
    tick();
    s_ready = 1;
    settle();
    chk("t3_m1_ready", o_m1_ready[0], 1);
    tick();
    m1_valid = 0; s_ready = 0;
    cycle(1);

    // Watchdog expiry on the 8th busy cycle, master 1 pending.
    do_reset();
    m0_valid = 1; m1_valid = 1; m1_wstrb = 4'b0000;
    cycle(1 + 7);
    settle();
    chk("t4_m0_ready", o_m0_ready[0], 1);
    chk("t4_pulse", o_tmo[0], 1);
    chk("t4_rdata", o_m0_rdata[0], TRD);
    chk("t4_s_valid", o_s_valid[0], 0);
    tick();
    m0_valid = 0;
    cycle(1);
    settle();
    chk("t4_next_grant", o_grant_id[0], 1);
    tick();

    // Slave response exactly on the expiry cycle.
    cycle(6);
    s_ready = 1; s_rdata = 32'hCAFE_F00D;
    settle();
    chk("t5_m1_ready", o_m1_ready[0], 1);
    chk("t5_m1_rdata", o_m1_rdata[0], 32'hCAFE_F00D);
    chk("t5_pulse", o_tmo[0], 0);
    tick();
    m1_valid = 0; s_ready = 0;
    cycle(1);

    // Reset while master 1 owns the bus.
    m1_valid = 1;
    cycle(1);
    reset = 1;
    settle();
    chk("t6_pre_grant", o_grant_id[0], 1);
    tick();
    reset = 0; m0_valid = 1;
    settle();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t6_busy_u%0d", k), o_busy[k], 0);
      chk($sformatf("t6_s_valid_u%0d", k), o_s_valid[k], 0);
      chk($sformatf("t6_m1_ready_u%0d", k), o_m1_ready[k], 0);
    end
    tick();
    settle();
    chk("t6_rr_grant", o_grant_id[0], 0);
    chk("t6_fp_grant", o_grant_id[1], 0);
    tick();

    // Randomized traffic with sticky requests and windows of slow slaves.
    for (int w = 0; w < 60; w++) begin
      int rdy_pct;
      rdy_pct = (w % 3 == 0) ? 50 : ((w % 3 == 1) ? 10 : 0);
      for (int i = 0; i < 50; i++) begin
        reset    = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 7) == 0) m0_valid = ~m0_valid;
        if ($urandom_range(0, 7) == 0) m1_valid = ~m1_valid;
        m0_addr  = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
        m1_addr  = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
        s_ready  = ($urandom_range(0, 99) < rdy_pct);
        s_rdata  = $urandom;
        cycle(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
